// File: rtl/button_reader_pkg.sv
// Shared types and helpers for the push-button reader:
// FSM state encoding and a ceil-log2 counter-width function.
package button_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // Bits needed to hold 0 .. n-1 (never less than 1).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for the raw button pad level.
// Ports: clk, reset (sync, active-high), d (async in), q (synced out).
module button_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader with press/release/long strobes
// and a wrapping 4-bit press counter.
// Ports: clk, reset (sync, active-high), btn_in (raw pad),
//   count_clr; btn_level, press_pulse, release_pulse,
//   long_pulse, press_count[3:0].
module button_reader
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 120000,
  parameter int LONG_PRESS_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       count_clr,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [3:0] press_count
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_PRESS_CYCLES);

  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE =
    HW'(LONG_PRESS_CYCLES - 2);

  logic btn_sync;

  state_e  state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic [3:0] count_q, count_d;

  button_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        db_cnt_d = '0;
        if (btn_sync) state_d = ST_PRESS_WAIT;
      end

      ST_PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d  = ST_IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_PRESSED;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          press_d    = 1'b1;
          level_d    = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      ST_PRESSED: begin
        db_cnt_d = '0;
        if (!btn_sync) begin
          // Hold count freezes while the release is judged.
          state_d = ST_RELEASE_WAIT;
        end else if (hold_cnt_q != HOLD_LAST) begin
          // Saturation makes the long strobe one-shot.
          hold_cnt_d = hold_cnt_q + 1'b1;
          long_d     = (hold_cnt_q == HOLD_PRE);
        end
      end

      ST_RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d  = ST_PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = ST_IDLE;
          db_cnt_d  = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // Clear beats a coincident press strobe.
  always_comb begin
    count_d = count_q;
    if (count_clr)    count_d = '0;
    else if (press_q) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      count_q    <= count_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader (DEBOUNCE=4, LONG=16).
// Stimulus queues expected strobes; a monitor pops and checks.
module tb_button_reader;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int kind;
    int cyc;
    int lvl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       count_clr = 1'b0;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [3:0] press_count;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  button_reader #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_in        (btn_in),
    .count_clr     (count_clr),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int req);
    n_chk = n_chk + 1;
    if (act == req) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  nm, act, req, cyc);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int k, int c, int l);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    e.lvl  = l;
    sb.push_back(e);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_level"}, int'(btn_level), 0);
    chk({nm, "_pulses"},
        int'(press_pulse) + int'(release_pulse) +
        int'(long_pulse), 0);
    chk({nm, "_count"}, int'(press_count), 0);
  endtask

  // Clean press: first sampling edge e gives press at e+6,
  // release at r+6 where r is the first edge sampling low.
  task automatic do_press(int hold, int gap, bit lng);
    int e;
    int r;
    @(negedge clk);
    btn_in = 1'b1;
    e = cyc + 1;
    push(K_PRESS, e + 6, 1);
    if (lng) push(K_LONG, e + 21, 1);
    tick(hold);
    btn_in = 1'b0;
    r = cyc + 1;
    push(K_REL, r + 6, 0);
    tick(gap);
  endtask

  // Monitor: every strobe is popped and checked.
  always @(negedge clk) begin
    int k;
    exp_t e;
    if (press_pulse || release_pulse || long_pulse) begin
      k = press_pulse ? K_PRESS :
          release_pulse ? K_REL : K_LONG;
      chk("pulse_exclusive",
          int'(press_pulse) + int'(release_pulse) +
          int'(long_pulse), 1);
      if (sb.size() == 0) begin
        chk("unexpected_pulse_kind", k, -1);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_level", int'(btn_level), e.lvl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int x;

    // Reset state
    tick(3);
    chk_zero("reset");
    reset = 1'b0;
    tick(2);

    // Bounce: never stable long enough
    for (int i = 0; i < 5; i++) begin
      btn_in = 1'b1;
      tick(3);
      btn_in = 1'b0;
      tick(1);
    end
    tick(10);
    chk("bounce_count", int'(press_count), 0);
    chk("bounce_level", int'(btn_level), 0);

    // Clean press
    do_press(8, 10, 1'b0);
    chk("clean_count", int'(press_count), 1);

    // Long hold of 40 cycles
    do_press(40, 10, 1'b1);
    chk("long_count", int'(press_count), 2);

    // Release glitch: low 2 cycles while pressed
    @(negedge clk);
    btn_in = 1'b1;
    e = cyc + 1;
    push(K_PRESS, e + 6, 1);
    tick(8);
    btn_in = 1'b0;
    tick(2);
    btn_in = 1'b1;
    tick(3);
    chk("glitch_level", int'(btn_level), 1);
    tick(1);
    btn_in = 1'b0;
    push(K_REL, cyc + 7, 0);
    tick(10);
    chk("glitch_count", int'(press_count), 3);

    // Wrap: 13 more presses reach 16 -> 0
    for (int i = 0; i < 13; i++) do_press(8, 8, 1'b0);
    chk("wrap_count", int'(press_count), 0);

    // 17th press with coincident clear
    @(negedge clk);
    btn_in = 1'b1;
    e = cyc + 1;
    push(K_PRESS, e + 6, 1);
    tick(7);
    chk("clr_pulse_seen", int'(press_pulse), 1);
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    chk("clr_wins", int'(press_count), 0);
    btn_in = 1'b0;
    push(K_REL, cyc + 7, 0);
    tick(10);

    // Reset while pressed, button still held
    @(negedge clk);
    btn_in = 1'b1;
    e = cyc + 1;
    push(K_PRESS, e + 6, 1);
    tick(9);
    chk("pre_reset_level", int'(btn_level), 1);
    reset = 1'b1;
    tick(1);
    chk_zero("midreset");
    reset = 1'b0;
    x = cyc;
    push(K_PRESS, x + 7, 1);
    tick(9);
    chk("repress_count", int'(press_count), 1);
    btn_in = 1'b0;
    push(K_REL, cyc + 7, 0);
    tick(12);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
